// File: rtl/ship_sprite_rom.sv
// Multi-sprite 1-bpp ship bitmap ROM: returns one row, or one column assembled by a row scan,
// optionally mirrored, through a req/valid handshake.
module ship_sprite_rom #(
  parameter int unsigned SIZE        = 48,
  parameter int unsigned NUM_SPRITES = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic [$clog2(NUM_SPRITES)-1:0] sprite_id,
  input  logic [$clog2(SIZE)-1:0]        line,
  input  logic                           vertical,
  input  logic                           mirror,
  output logic                           busy,
  output logic                           line_valid,
  output logic                           line_err,
  output logic [SIZE-1:0]                line_pixels
);

  localparam int unsigned SW = $clog2(NUM_SPRITES);
  localparam int unsigned RW = $clog2(SIZE);

  typedef enum logic [2:0] {IDLE, HREAD, VSCAN, VLAST, OUT} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   s_r;
  logic [RW-1:0]   line_r;
  logic [RW-1:0]   cnt;
  logic            mirror_r, vert_r, err_r;
  logic [SIZE-1:0] rom_q, data_r, asm_r, result_c;
  logic            accept_c, range_err_c, rd_en_c;
  logic [SW-1:0]   rd_s_c;
  logic [RW-1:0]   rd_r_c;

  function automatic logic [SIZE-1:0] reverse(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SIZE); i++) r[i] = v[SIZE-1-i];
    return r;
  endfunction

  // Top half of each sprite lit, starting at column equal to the sprite index
  function automatic logic [SIZE-1:0] pattern(input logic [SW-1:0] s, input logic [RW-1:0] r);
    logic [SIZE-1:0] w;
    w = '0;
    for (int c = 0; c < int'(SIZE); c++)
      w[SIZE-1-c] = (32'(r) < SIZE / 2) && (32'(c) >= 32'(s));
    return w;
  endfunction

  assign accept_c    = req & ~busy;
  assign range_err_c = (32'(line) >= SIZE) || (32'(sprite_id) >= NUM_SPRITES);
  assign result_c    = vert_r ? asm_r : data_r;

  // Next state and ROM read port; in IDLE/OUT the address comes straight from the inputs
  always_comb begin
    state_nx = state;
    rd_en_c  = 1'b0;
    rd_s_c   = s_r;
    rd_r_c   = cnt;
    case (state)
      IDLE, OUT: begin
        state_nx = IDLE;
        if (accept_c) begin
          rd_s_c   = sprite_id;
          rd_r_c   = vertical ? '0 : line;
          rd_en_c  = ~range_err_c;
          state_nx = (vertical && !range_err_c) ? VSCAN : HREAD;
        end
      end
      HREAD: state_nx = OUT;
      VSCAN: begin
        rd_en_c = 1'b1;
        if (cnt == RW'(SIZE - 1)) state_nx = VLAST;
      end
      VLAST:   state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      line_valid  <= 1'b0;
      line_err    <= 1'b0;
      line_pixels <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx == HREAD) || (state_nx == VSCAN) || (state_nx == VLAST);
      line_valid <= (state == OUT);
      line_err   <= (state == OUT) && err_r;
      if (state == OUT)
        line_pixels <= err_r ? '0 : (mirror_r ? reverse(result_c) : result_c);
    end
  end

  // Request capture, row counter and column assembly
  always_ff @(posedge clk) begin
    if (accept_c) begin
      s_r      <= sprite_id;
      line_r   <= line;
      mirror_r <= mirror;
      vert_r   <= vertical;
      err_r    <= range_err_c;
      cnt      <= RW'(1);
    end else if (state == VSCAN) begin
      cnt <= cnt + RW'(1);
    end
    if (state == HREAD) data_r <= rom_q;
    if (state == VSCAN || state == VLAST)
      asm_r <= {asm_r[SIZE-2:0], rom_q[RW'(SIZE - 1) - line_r]};
  end

  // Synchronous ROM read
  always_ff @(posedge clk) begin
    if (rd_en_c) rom_q <= pattern(rd_s_c, rd_r_c);
  end

endmodule
